id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage directly upstream of the ALU.
- Latches decoded instruction fields and control bits, then produces the ALU's 4-bit control code and both 32-bit operands.
- Operands pass through EX/MEM and MEM/WB forwarding and the immediate select.
- Honours stall (hold) and flush (bubble) requests from the hazard unit.

Parameters:
- DW, 32, datapath width
- RW, 5, register-address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold current contents
- flush  in  1  load a bubble
- id_rs_data, id_rt_data  in  DW each  register-file read data
- id_imm  in  DW  sign-extended immediate
- id_rs, id_rt, id_rd  in  RW each  register addresses
- id_funct  in  6  instruction funct field
- id_aluop  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type, 11 add (addi)
- id_alusrc, id_regdst, id_memread, id_memwrite, id_memtoreg, id_regwrite, id_branch  in  1 each  decoded controls
- exm_regwrite  in  1  EX/MEM write enable
- exm_rd  in  RW  EX/MEM destination
- exm_result  in  DW  EX/MEM ALU result
- wb_regwrite  in  1  MEM/WB write enable
- wb_rd  in  RW  MEM/WB destination
- wb_data  in  DW  MEM/WB writeback data
- alu_control  out  4  0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt
- alu_in1, alu_in2  out  DW each  ALU operands
- ex_store_data  out  DW  forwarded rt value, for sw
- ex_wreg  out  RW  destination: rd if regdst else rt
- ex_rs, ex_rt  out  RW each  registered addresses, for the hazard unit
- ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_branch  out  1 each  registered controls

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registered fields clear to 0, so every ex_* control is 0.
  - aluop 00, so alu_control = 0010.
  - alu_in1 = alu_in2 = 0 unless forwarding hits.
- Rising clk, priority flush > stall > load:
  - flush: all controls 0, data and addresses 0 (bubble).
  - stall and not flush: every register holds.
  - otherwise: capture all id_* inputs.
- Latency: one cycle from id_* to the registered outputs.
- alu_control, alu_in1/2, ex_store_data and ex_wreg are combinational from the registered state and the forwarding inputs within the same cycle.
- ALU control decode:
  - aluop 00 or 11: 0010. aluop 01: 0110.
  - aluop 10, by funct: 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111.
  - Any other funct: 0000.
- Forwarding, for operand A on ex_rs and operand B on ex_rt:
  - If exm_regwrite and exm_rd != 0 and exm_rd matches: use exm_result.
  - Else if wb_regwrite and wb_rd != 0 and wb_rd matches: use wb_data.
  - Else use the registered register data.
  - EX/MEM beats MEM/WB when both match.
  - Register 0 never forwards.
- alu_in1 = forwarded A.
- alu_in2 = registered imm if alusrc, else forwarded B.
- ex_store_data = forwarded B regardless of alusrc.
- Reset deasserting mid-stall: first edge after release loads a bubble if flush, else id_* per normal priority.

Optional Feature:
- Macro ID_EX_FWD_EN.
- Defined: forwarding exactly as above.
- Undefined:
  - Forwarding muxes are absent; exm_* and wb_* inputs are ignored.
  - alu_in1 = registered rs data; alu_in2/ex_store_data use registered rt data.
  - Software or stalls must resolve hazards.

Decomposition:
- Shared package:
  - ALU control encodings (AND, OR, ADD, SUB, SLT).
  - ALUOp encodings.
  - funct codes.
  - DW/RW defaults.
- One sub-module: alu_ctrl, combinational aluop+funct → 4-bit code; reusable by the single-cycle datapath.

Test Plan:
- Reset: rst_n low mid-cycle → all ex_* 0 immediately, alu_control 0010; release, load add R-type (aluop 10, funct 100000, rs_data 5, rt_data 7) → next cycle alu_control 0010, in1 5, in2 7.
- Decode sweep: aluop 10 with funct 100010/100100/100101/101010/111111 → 0110/0000/0001/0111/0000; aluop 01 → 0110; aluop 11 → 0010.
- Forwarding:
  - ex_rs = 3, exm_rd = 3, exm_regwrite 1, exm_result 0xAA, wb_rd = 3, wb_data 0xBB → alu_in1 0xAA.
  - Drop exm_regwrite → alu_in1 0xBB.
  - exm_rd = 0 → no forward.
- Immediate and store: alusrc 1, imm 0xFFFFFFFC, rt forwarded from wb_data 0x1234 → alu_in2 0xFFFFFFFC, ex_store_data 0x1234.
- Stall/flush:
  - stall 2 cycles with changing id_* → outputs frozen.
  - stall+flush together → all controls 0 next edge.
- Macro off: identical forwarding scenario → alu_in1 equals registered rs_data.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage and ALU control decode.
// Holds ALU control codes, ALUOp classes, R-type funct codes and width defaults.
package id_ex_stage_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ADDI  = 2'b11
    } aluop_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/id_ex_stage_alu_ctrl.sv
// Combinational ALUOp + funct to 4-bit ALU control decode.
// Shared with the single-cycle datapath; unknown R-type funct yields AND.
module alu_ctrl
    import id_ex_stage_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_AND;
        case (aluop)
            ALUOP_ADD, ALUOP_ADDI: alu_control = ALU_ADD;
            ALUOP_SUB:             alu_control = ALU_SUB;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   alu_control = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, forwarding and immediate select.
// Define ID_EX_FWD_EN to build the EX/MEM and MEM/WB forwarding muxes.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [5:0]    id_funct,
    input  logic [1:0]    id_aluop,
    input  logic          id_alusrc,
    input  logic          id_regdst,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          id_regwrite,
    input  logic          id_branch,
    input  logic          exm_regwrite,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_regwrite,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [3:0]    alu_control,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_wreg,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic          ex_regwrite,
    output logic          ex_branch
);

    logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
    logic [RW-1:0] rd_q;
    logic [5:0]    funct_q;
    logic [1:0]    aluop_q;
    logic          alusrc_q, regdst_q;
    logic [DW-1:0] fwd_a, fwd_b;

    // A bubble clears every field so a flushed slot can never forward or write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            funct_q     <= '0;
            aluop_q     <= '0;
            alusrc_q    <= 1'b0;
            regdst_q    <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_branch   <= 1'b0;
        end else if (!stall) begin
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm;
            rd_q        <= id_rd;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            funct_q     <= id_funct;
            aluop_q     <= id_aluop;
            alusrc_q    <= id_alusrc;
            regdst_q    <= id_regdst;
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
            ex_memtoreg <= id_memtoreg;
            ex_regwrite <= id_regwrite;
            ex_branch   <= id_branch;
        end
    end

`ifdef ID_EX_FWD_EN
    // The younger EX/MEM result wins; register 0 is hardwired and never forwards.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] src,
        input logic [DW-1:0] reg_val,
        input logic          em_we,
        input logic [RW-1:0] em_rd,
        input logic [DW-1:0] em_val,
        input logic          w_we,
        input logic [RW-1:0] w_rd,
        input logic [DW-1:0] w_val
    );
        if (em_we && (em_rd != '0) && (em_rd == src)) return em_val;
        if (w_we && (w_rd != '0) && (w_rd == src))    return w_val;
        return reg_val;
    endfunction

    assign fwd_a = fwd_sel(ex_rs, rs_data_q, exm_regwrite, exm_rd, exm_result,
                           wb_regwrite, wb_rd, wb_data);
    assign fwd_b = fwd_sel(ex_rt, rt_data_q, exm_regwrite, exm_rd, exm_result,
                           wb_regwrite, wb_rd, wb_data);
`else
    logic unused_fwd;
    assign unused_fwd = ^{exm_regwrite, exm_rd, exm_result, wb_regwrite, wb_rd, wb_data};
    assign fwd_a      = rs_data_q;
    assign fwd_b      = rt_data_q;
`endif

    assign alu_in1       = fwd_a;
    assign alu_in2       = alusrc_q ? imm_q : fwd_b;
    assign ex_store_data = fwd_b;
    assign ex_wreg       = regdst_q ? rd_q : ex_rt;

    alu_ctrl u_alu_ctrl (
        .aluop       (aluop_q),
        .funct       (funct_q),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode table, reset, forwarding, immediate, stall/flush.
// Forwarding expectations follow whether ID_EX_FWD_EN is defined for the build.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic [1:0]  id_aluop;
    logic        id_alusrc, id_regdst, id_memread, id_memwrite, id_memtoreg, id_regwrite, id_branch;
    logic        exm_regwrite, wb_regwrite;
    logic [4:0]  exm_rd, wb_rd;
    logic [31:0] exm_result, wb_data;
    logic [3:0]  alu_control;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [4:0]  ex_wreg, ex_rs, ex_rt;
    logic        ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_branch;

    int vectors = 0;
    int errors  = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_aluop(id_aluop),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
        .id_branch(id_branch),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .alu_control(alu_control), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .ex_store_data(ex_store_data), .ex_wreg(ex_wreg), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_branch(ex_branch)
    );

    always #5 clk = ~clk;

    // ctl = {alusrc, regdst, memread, memwrite, memtoreg, regwrite, branch}
    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
        logic [6:0]  ctl;
        logic [3:0]  e_alu;
        logic [31:0] e_in1, e_in2, e_store;
        logic [4:0]  e_wreg;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(
        input logic [1:0] aluop, input logic [5:0] funct,
        input logic [31:0] rs_data, input logic [31:0] rt_data, input logic [31:0] imm,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [6:0] ctl,
        input logic [3:0] e_alu, input logic [31:0] e_in1, input logic [31:0] e_in2,
        input logic [31:0] e_store, input logic [4:0] e_wreg);
        vec_t v;
        v.aluop = aluop; v.funct = funct; v.rs_data = rs_data; v.rt_data = rt_data;
        v.imm = imm; v.rs = rs; v.rt = rt; v.rd = rd; v.ctl = ctl;
        v.e_alu = e_alu; v.e_in1 = e_in1; v.e_in2 = e_in2; v.e_store = e_store; v.e_wreg = e_wreg;
        return v;
    endfunction

    function automatic logic [119:0] obs();
        return {alu_control, alu_in1, alu_in2, ex_store_data, ex_wreg, ex_rs, ex_rt,
                ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_branch};
    endfunction

    function automatic logic [119:0] exp_of(input vec_t v);
        return {v.e_alu, v.e_in1, v.e_in2, v.e_store, v.e_wreg, v.rs, v.rt, v.ctl[4:0]};
    endfunction

    localparam logic [119:0] BUBBLE = {4'b0010, 116'd0};

    task automatic check(input string name, input logic [119:0] act, input logic [119:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_aluop = v.aluop; id_funct = v.funct; id_rs_data = v.rs_data; id_rt_data = v.rt_data;
        id_imm = v.imm; id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
        {id_alusrc, id_regdst, id_memread, id_memwrite, id_memtoreg, id_regwrite, id_branch} = v.ctl;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wdat);
        exm_regwrite = ew; exm_rd = erd; exm_result = eres;
        wb_regwrite = ww; wb_rd = wrd; wb_data = wdat;
    endtask

    task automatic load(input vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #2;
    endtask

    initial begin
        vec_t f;
        tbl[0] = mk(2'b10, 6'h20, 32'd5,        32'd7,      32'd0,        5'd1, 5'd2,  5'd3,  7'b0100010, 4'b0010, 32'd5,        32'd7,        32'd7,      5'd3);
        tbl[1] = mk(2'b10, 6'h22, 32'd10,       32'd3,      32'd0,        5'd4, 5'd5,  5'd6,  7'b0100010, 4'b0110, 32'd10,       32'd3,        32'd3,      5'd6);
        tbl[2] = mk(2'b10, 6'h24, 32'hF0F0,     32'h0FF0,   32'd0,        5'd7, 5'd8,  5'd9,  7'b0100010, 4'b0000, 32'hF0F0,     32'h0FF0,     32'h0FF0,   5'd9);
        tbl[3] = mk(2'b10, 6'h25, 32'd1,        32'd2,      32'd0,        5'd1, 5'd2,  5'd10, 7'b0100010, 4'b0001, 32'd1,        32'd2,        32'd2,      5'd10);
        tbl[4] = mk(2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1,      32'd0,        5'd3, 5'd4,  5'd11, 7'b0100010, 4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,      5'd11);
        tbl[5] = mk(2'b10, 6'h3F, 32'd8,        32'd9,      32'd0,        5'd5, 5'd6,  5'd12, 7'b0100010, 4'b0000, 32'd8,        32'd9,        32'd9,      5'd12);
        tbl[6] = mk(2'b01, 6'h20, 32'd4,        32'd4,      32'd8,        5'd1, 5'd2,  5'd3,  7'b0000001, 4'b0110, 32'd4,        32'd4,        32'd4,      5'd2);
        tbl[7] = mk(2'b11, 6'h22, 32'd6,        32'd9,      32'h10,       5'd2, 5'd7,  5'd31, 7'b1000010, 4'b0010, 32'd6,        32'h10,       32'd9,      5'd7);
        tbl[8] = mk(2'b00, 6'h00, 32'h100,      32'h55,     32'hFFFFFFFC, 5'd8, 5'd9,  5'd1,  7'b1010110, 4'b0010, 32'h100,      32'hFFFFFFFC, 32'h55,     5'd9);
        tbl[9] = mk(2'b00, 6'h00, 32'h200,      32'hDEAD,   32'd4,        5'd8, 5'd10, 5'd1,  7'b1001000, 4'b0010, 32'h200,      32'd4,        32'hDEAD,   5'd10);

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(tbl[0]);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #2 check("reset_state", obs(), BUBBLE);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            load(tbl[i]);
            check($sformatf("table[%0d]", i), obs(), exp_of(tbl[i]));
        end

        // asynchronous reset asserted mid-cycle, then a first load after release
        #1 rst_n = 1'b0;
        #1 check("async_reset", obs(), BUBBLE);
        @(negedge clk) rst_n = 1'b1;
        load(tbl[0]);
        check("post_reset_add", obs(), exp_of(tbl[0]));

        // forwarding on operand A (rs = 3) and operand B (rt = 4)
        f = mk(2'b10, 6'h20, 32'h11, 32'h22, 32'd0, 5'd3, 5'd4, 5'd5, 7'b0100010,
               4'b0010, 32'h11, 32'h22, 32'h22, 5'd5);
        load(f);
        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        #1;
`ifdef ID_EX_FWD_EN
        check("fwd_exm_beats_wb", {88'd0, alu_in1}, {88'd0, 32'hAA});
`else
        check("nofwd_exm_wb", {88'd0, alu_in1}, {88'd0, 32'h11});
`endif
        set_fwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        #1;
`ifdef ID_EX_FWD_EN
        check("fwd_wb_only", {88'd0, alu_in1}, {88'd0, 32'hBB});
`else
        check("nofwd_wb", {88'd0, alu_in1}, {88'd0, 32'h11});
`endif
        set_fwd(1'b1, 5'd0, 32'hAA, 1'b0, 5'd3, 32'hBB);
        #1 check("fwd_exm_rd0", {88'd0, alu_in1}, {88'd0, 32'h11});
        set_fwd(1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 32'd0);
        #1;
`ifdef ID_EX_FWD_EN
        check("fwd_b_exm", {56'd0, alu_in2, ex_store_data}, {56'd0, 32'h55, 32'h55});
`else
        check("nofwd_b", {56'd0, alu_in2, ex_store_data}, {56'd0, 32'h22, 32'h22});
`endif
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // immediate select while rt is forwarded from writeback
        f = mk(2'b11, 6'h00, 32'h11, 32'h22, 32'hFFFFFFFC, 5'd3, 5'd4, 5'd5, 7'b1000010,
               4'b0010, 32'h11, 32'hFFFFFFFC, 32'h22, 5'd4);
        load(f);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h1234);
        #1;
`ifdef ID_EX_FWD_EN
        check("imm_store_fwd", {56'd0, alu_in2, ex_store_data}, {56'd0, 32'hFFFFFFFC, 32'h1234});
`else
        check("imm_store_nofwd", {56'd0, alu_in2, ex_store_data}, {56'd0, 32'hFFFFFFFC, 32'h22});
`endif
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // stall for two edges with changing inputs, then stall+flush together
        load(tbl[4]);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            stall = 1'b1;
            drive(tbl[5 + k]);
            @(posedge clk);
            #2 check($sformatf("stall_hold[%0d]", k), obs(), exp_of(tbl[4]));
        end
        @(negedge clk);
        flush = 1'b1;
        drive(tbl[8]);
        @(posedge clk);
        #2 check("stall_flush_bubble", obs(), BUBBLE);
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        load(tbl[1]);
        check("resume_after_flush", obs(), exp_of(tbl[1]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
